// File: rtl/seq_memory_stage.sv
// SEQ Y86-64 memory stage: 8-byte little-endian data memory with sticky error and write counter.
// Optional range checking is enabled by defining SEQ_MEM_BOUNDS_CHECK_EN.
module seq_memory_stage #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       icode,
  input  logic [63:0]      valA,
  input  logic [63:0]      valE,
  input  logic [63:0]      valP,
  output logic [63:0]      valM,
  output logic             dmem_error,
  output logic             mem_halt,
  output logic [CNT_W-1:0] wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  logic [7:0]        mem [DEPTH];
  logic              rd;
  logic              wr;
  logic              oob;
  logic              wr_en;
  logic [63:0]       addr;
  logic [63:0]       wdata;
  logic [ADDR_W-1:0] idx [8];

  always_comb begin
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = valE;
    wdata = valA;
    case (icode)
      I_RMMOVQ: wr = 1'b1;
      I_MRMOVQ: rd = 1'b1;
      I_CALL: begin
        wr    = 1'b1;
        wdata = valP;
      end
      I_RET: begin
        rd   = 1'b1;
        addr = valA;
      end
      I_PUSHQ: wr = 1'b1;
      I_POPQ: begin
        rd   = 1'b1;
        addr = valA;
      end
      default: ;
    endcase
  end

`ifdef SEQ_MEM_BOUNDS_CHECK_EN
  localparam logic [63:0] MAX_ADDR = 64'(DEPTH - 8);
  assign oob = (addr > MAX_ADDR);
`else
  assign oob = 1'b0;
`endif

  assign dmem_error = (rd | wr) & oob;
  assign wr_en      = wr & ~dmem_error & ~mem_halt;

  // Byte indices wrap modulo DEPTH; with range checking on, a legal access never wraps.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      idx[k] = addr[ADDR_W-1:0] + ADDR_W'(k);
    end
  end

  always_comb begin
    valM = '0;
    if (rd && !dmem_error) begin
      for (int k = 0; k < 8; k++) begin
        valM[8*k +: 8] = mem[idx[k]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int k = 0; k < 8; k++) begin
        mem[idx[k]] <= wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_halt <= 1'b0;
      wr_count <= '0;
    end else begin
      if (dmem_error) begin
        mem_halt <= 1'b1;
      end
      if (wr_en) begin
        wr_count <= wr_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_memory_stage.sv
// Bench for seq_memory_stage: directed scenarios plus randomized traffic against a byte-array model.
// Honors SEQ_MEM_BOUNDS_CHECK_EN the same way as the design.
module tb_seq_memory_stage;

  localparam int ADDR_W = 10;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 2 ** ADDR_W;
`ifdef SEQ_MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       icode;
  logic [63:0]      valA, valE, valP;
  logic [63:0]      valM;
  logic             dmem_error;
  logic             mem_halt;
  logic [CNT_W-1:0] wr_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  m_mem [DEPTH];
  logic        m_halt;
  int unsigned m_count;

  seq_memory_stage #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .icode(icode), .valA(valA), .valE(valE), .valP(valP),
    .valM(valM), .dmem_error(dmem_error), .mem_halt(mem_halt), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // Reference model: spec-level decode and a plain byte array.
  function automatic bit m_rd();
    return icode inside {4'h5, 4'h9, 4'hB};
  endfunction
  function automatic bit m_wr();
    return icode inside {4'h4, 4'h8, 4'hA};
  endfunction
  function automatic logic [63:0] m_addr();
    return (icode == 4'h9 || icode == 4'hB) ? valA : valE;
  endfunction
  function automatic bit m_err();
    return BOUNDS && (m_rd() || m_wr()) && (m_addr() > 64'(DEPTH - 8));
  endfunction
  function automatic logic [63:0] m_load(input logic [63:0] a);
    logic [63:0] r = '0;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = m_mem[((a % DEPTH) + k) % DEPTH];
    return r;
  endfunction
  function automatic logic [63:0] m_valM();
    return (m_rd() && !m_err()) ? m_load(m_addr()) : 64'd0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    m_halt  = 1'b0;
    m_count = 0;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                       input logic [63:0] p);
    icode = ic; valA = a; valE = e; valP = p;
    #1;
  endtask

  // One rising edge; the model applies the commit rules for whatever was presented.
  task automatic tick();
    bit          err  = m_err();
    bit          wr   = m_wr();
    logic [63:0] a    = m_addr();
    logic [63:0] d    = (icode == 4'h8) ? valP : valA;
    @(posedge clk);
    if (rst_n) begin
      if (err) m_halt = 1'b1;
      else if (wr && !m_halt) begin
        for (int k = 0; k < 8; k++) m_mem[((a % DEPTH) + k) % DEPTH] = d[8*k +: 8];
        m_count = m_count + 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_reset();
    drive(4'h5, 64'd0, 64'h10, 64'd0);
    n_checks += 4;
    if (valM !== 64'd0) begin n_errors++; $display("FAIL rst_valM got %h exp 0", valM); end
    if (dmem_error !== 1'b0) begin n_errors++; $display("FAIL rst_err got %b exp 0", dmem_error); end
    if (mem_halt !== 1'b0) begin n_errors++; $display("FAIL rst_halt got %b exp 0", mem_halt); end
    if (wr_count !== '0) begin n_errors++; $display("FAIL rst_cnt got %0d exp 0", wr_count); end
    drive(4'h4, 64'hAAAA_BBBB_CCCC_DDDD, 64'h40, 64'd0);
    tick();
    drive(4'h5, 64'd0, 64'h40, 64'd0);
    n_checks += 2;
    if (valM !== 64'd0) begin n_errors++; $display("FAIL rst_nowrite got %h exp 0", valM); end
    if (wr_count !== '0) begin n_errors++; $display("FAIL rst_nowrite_cnt got %0d exp 0", wr_count); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'h5, 64'd0, 64'h10, 64'd0);
    n_checks += 3;
    if (valM !== 64'd0) begin n_errors++; $display("FAIL post_rst_valM got %h exp 0", valM); end
    if (dmem_error !== 1'b0) begin n_errors++; $display("FAIL post_rst_err got %b exp 0", dmem_error); end
    if (wr_count !== '0) begin n_errors++; $display("FAIL post_rst_cnt got %0d exp 0", wr_count); end
  endtask

  task automatic test_store_load();
    drive(4'h4, 64'h0123_4567_89AB_CDEF, 64'h10, 64'd0);
    tick();
    drive(4'h5, 64'd0, 64'h10, 64'd0);
    n_checks += 3;
    if (valM !== 64'h0123_4567_89AB_CDEF) begin n_errors++; $display("FAIL load_aligned got %h exp 0123456789abcdef", valM); end
    if (wr_count !== 4'd1) begin n_errors++; $display("FAIL store_cnt got %0d exp 1", wr_count); end
    if (dmem_error !== 1'b0) begin n_errors++; $display("FAIL store_err got %b exp 0", dmem_error); end
    drive(4'h5, 64'd0, 64'h11, 64'd0);
    n_checks++;
    if (valM !== 64'h0001_2345_6789_ABCD) begin n_errors++; $display("FAIL load_offset got %h exp 000123456789abcd", valM); end
  endtask

  task automatic test_call_ret_push_pop();
    drive(4'h8, 64'd0, 64'h3F8, 64'h30);
    tick();
    drive(4'h9, 64'h3F8, 64'd0, 64'd0);
    n_checks++;
    if (valM !== 64'h30) begin n_errors++; $display("FAIL ret got %h exp 30", valM); end
    drive(4'hA, 64'hFEED_FACE_DEAD_BEEF, 64'h100, 64'd0);
    tick();
    drive(4'hB, 64'h100, 64'd0, 64'd0);
    n_checks += 2;
    if (valM !== 64'hFEED_FACE_DEAD_BEEF) begin n_errors++; $display("FAIL pop got %h exp feedfacedeadbeef", valM); end
    if (wr_count !== CNT_W'(m_count)) begin n_errors++; $display("FAIL push_cnt got %0d exp %0d", wr_count, CNT_W'(m_count)); end
  endtask

  task automatic test_random();
    logic [3:0]  ic;
    logic [63:0] a, e, p;
    for (int it = 0; it < 200; it++) begin
      ic = 4'($urandom_range(0, 11));
      e  = 64'($urandom_range(0, DEPTH - 8));
      p  = {$urandom, $urandom};
      a  = (ic == 4'h9 || ic == 4'hB) ? 64'($urandom_range(0, DEPTH - 8)) : {$urandom, $urandom};
      if (!BOUNDS && ($urandom_range(0, 7) == 0)) e = {$urandom, $urandom};
      if (ic == 4'h5 || ic == 4'h9 || ic == 4'hB) e = (ic == 4'h5) ? 64'($urandom_range(0, 80)) : e;
      drive(ic, a, e, p);
      n_checks += 2;
      if (valM !== m_valM()) begin n_errors++; $display("FAIL rnd_valM it=%0d ic=%h got %h exp %h", it, ic, valM, m_valM()); end
      if (dmem_error !== m_err()) begin n_errors++; $display("FAIL rnd_err it=%0d got %b exp %b", it, dmem_error, m_err()); end
      tick();
      n_checks += 2;
      if (wr_count !== CNT_W'(m_count)) begin n_errors++; $display("FAIL rnd_cnt it=%0d got %0d exp %0d", it, wr_count, CNT_W'(m_count)); end
      if (mem_halt !== m_halt) begin n_errors++; $display("FAIL rnd_halt it=%0d got %b exp %b", it, mem_halt, m_halt); end
    end
  endtask

`ifdef SEQ_MEM_BOUNDS_CHECK_EN
  task automatic test_bounds_error();
    logic [CNT_W-1:0] cnt0 = wr_count;
    drive(4'h4, 64'h1111, 64'h3F9, 64'd0);
    n_checks++;
    if (dmem_error !== 1'b1) begin n_errors++; $display("FAIL oob_err got %b exp 1", dmem_error); end
    tick();
    n_checks += 2;
    if (mem_halt !== 1'b1) begin n_errors++; $display("FAIL oob_halt got %b exp 1", mem_halt); end
    if (wr_count !== cnt0) begin n_errors++; $display("FAIL oob_cnt got %0d exp %0d", wr_count, cnt0); end
    drive(4'h4, 64'h5555_6666_7777_8888, 64'h3F0, 64'd0);
    tick();
    drive(4'h5, 64'd0, 64'h3F0, 64'd0);
    n_checks += 3;
    if (valM !== m_valM()) begin n_errors++; $display("FAIL halt_block got %h exp %h", valM, m_valM()); end
    if (valM === 64'h5555_6666_7777_8888) begin n_errors++; $display("FAIL halt_block_data got %h exp old data", valM); end
    if (wr_count !== cnt0) begin n_errors++; $display("FAIL halt_cnt got %0d exp %0d", wr_count, cnt0); end
    drive(4'h5, 64'd0, 64'h3F8, 64'd0);
    n_checks += 2;
    if (valM !== m_valM()) begin n_errors++; $display("FAIL halt_read got %h exp %h", valM, m_valM()); end
    if (dmem_error !== 1'b0) begin n_errors++; $display("FAIL edge_ok_err got %b exp 0", dmem_error); end
  endtask
`else
  task automatic test_wrap();
    drive(4'h4, 64'h1122_3344_5566_7788, 64'h3FC, 64'd0);
    n_checks++;
    if (dmem_error !== 1'b0) begin n_errors++; $display("FAIL wrap_err got %b exp 0", dmem_error); end
    tick();
    drive(4'h5, 64'd0, 64'h3FC, 64'd0);
    n_checks++;
    if (valM !== 64'h1122_3344_5566_7788) begin n_errors++; $display("FAIL wrap_read got %h exp 1122334455667788", valM); end
    drive(4'h5, 64'd0, 64'h0, 64'd0);
    n_checks++;
    if (valM[31:0] !== 32'h1122_3344) begin n_errors++; $display("FAIL wrap_low got %h exp 11223344", valM[31:0]); end
    drive(4'h5, 64'd0, 64'hFFFF_0000_0000_03FC, 64'd0);
    n_checks += 2;
    if (valM !== 64'h1122_3344_5566_7788) begin n_errors++; $display("FAIL trunc_read got %h exp 1122334455667788", valM); end
    if (mem_halt !== 1'b0) begin n_errors++; $display("FAIL wrap_halt got %b exp 0", mem_halt); end
  endtask
`endif

  task automatic test_async_reset();
    drive(4'h4, 64'hCAFE_0000_BEEF_1234, 64'h60, 64'd0);
    tick();
    drive(4'h5, 64'd0, 64'h60, 64'd0);
    #3;
    rst_n = 1'b0;
    m_reset();
    #1;
    n_checks += 3;
    if (valM !== 64'd0) begin n_errors++; $display("FAIL arst_valM got %h exp 0", valM); end
    if (mem_halt !== 1'b0) begin n_errors++; $display("FAIL arst_halt got %b exp 0", mem_halt); end
    if (wr_count !== '0) begin n_errors++; $display("FAIL arst_cnt got %0d exp 0", wr_count); end
    drive(4'h4, 64'h0BAD_F00D_0000_0042, 64'h50, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(4'h5, 64'd0, 64'h50, 64'd0);
    n_checks += 2;
    if (valM !== 64'h0BAD_F00D_0000_0042) begin n_errors++; $display("FAIL release_write got %h exp 0badf00d00000042", valM); end
    if (wr_count !== 4'd1) begin n_errors++; $display("FAIL release_cnt got %0d exp 1", wr_count); end
    drive(4'h3, 64'h77, 64'h50, 64'd0);
    n_checks++;
    if (valM !== 64'd0) begin n_errors++; $display("FAIL irmovq_valM got %h exp 0", valM); end
    tick();
    drive(4'h7, 64'h77, 64'h50, 64'h90);
    tick();
    drive(4'h5, 64'd0, 64'h50, 64'd0);
    n_checks += 2;
    if (wr_count !== 4'd1) begin n_errors++; $display("FAIL nonmem_cnt got %0d exp 1", wr_count); end
    if (valM !== 64'h0BAD_F00D_0000_0042) begin n_errors++; $display("FAIL nonmem_nowrite got %h exp 0badf00d00000042", valM); end
  endtask

  initial begin
    rst_n = 1'b0;
    icode = 4'h0; valA = '0; valE = '0; valP = '0;
    test_reset();
    test_store_load();
    test_call_ret_push_pop();
    test_random();
`ifdef SEQ_MEM_BOUNDS_CHECK_EN
    test_bounds_error();
`else
    test_wrap();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
